// File: rtl/bf_pkg.sv
// Shared constants and FSM state encoding for the bellmanford result path.
package bf_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8192;
    localparam logic [15:0] INF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        NEG   = 2'd2
    } state_t;

endpackage

// File: rtl/result_drain_rise_detect.sv
// Registered rising-edge detector; the history register tracks the input every
// cycle (including during reset), so a level already high at reset release is not an edge.
module rise_detect (
    input  logic clock,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock) begin
        prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/result_drain.sv
// Drains the bellmanford output memory onto a valid/ready stream on Finish,
// or emits a single negative-cycle status word on NegCycle.
module result_drain
    import bf_pkg::*;
#(
    parameter int              ADDR_W = bf_pkg::ADDR_W,
    parameter int              DATA_W = bf_pkg::DATA_W,
    parameter int              DEPTH  = bf_pkg::DEPTH,
    parameter logic [DATA_W-1:0] INF  = bf_pkg::INF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Finish,
    input  logic              NegCycle,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_unreach,
    output logic              out_neg,
    output logic              out_last,
    output logic              busy,
    output logic [ADDR_W:0]   unreach_count
);

    // rd_addr carries one extra bit so DEPTH == 2**ADDR_W cannot wrap before out_last.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    state_t              state, state_n;
    logic [ADDR_W:0]     rd_addr, rd_addr_n;
    logic                valid_n, unreach_n, neg_n, last_n, busy_n;
    logic [DATA_W-1:0]   data_n;
    logic [ADDR_W-1:0]   index_n;
    logic [ADDR_W:0]     count_n;
    logic                fin_rise, neg_rise, accept;

    rise_detect u_fin_rise (
        .clock (clock),
        .level (Finish),
        .rise  (fin_rise)
    );

    rise_detect u_neg_rise (
        .clock (clock),
        .level (NegCycle),
        .rise  (neg_rise)
    );

    assign OMAR   = rd_addr[ADDR_W-1:0];
    assign accept = out_valid & out_ready;

    always_comb begin
        state_n   = state;
        rd_addr_n = rd_addr;
        valid_n   = out_valid;
        data_n    = out_data;
        index_n   = out_index;
        unreach_n = out_unreach;
        neg_n     = out_neg;
        last_n    = out_last;
        busy_n    = busy;
        count_n   = unreach_count;

        unique case (state)
            IDLE: begin
                if (neg_rise) begin
                    state_n = NEG;
                    busy_n  = 1'b1;
                end else if (fin_rise) begin
                    state_n   = DRAIN;
                    rd_addr_n = '0;
                    count_n   = '0;
                    busy_n    = 1'b1;
                end
            end
            NEG: begin
                if (!out_valid) begin
                    valid_n   = 1'b1;
                    neg_n     = 1'b1;
                    last_n    = 1'b1;
                    unreach_n = 1'b0;
                    data_n    = '0;
                    index_n   = '0;
                end else if (out_ready) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    neg_n   = 1'b0;
                    last_n  = 1'b0;
                    busy_n  = 1'b0;
                end
            end
            DRAIN: begin
                if (accept && out_unreach) begin
                    count_n = unreach_count + ONE;
                end
                if (accept && out_last) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    busy_n  = 1'b0;
                end else if ((!out_valid || accept) && rd_addr <= LAST_ADDR) begin
                    valid_n   = 1'b1;
                    data_n    = OMDR;
                    index_n   = rd_addr[ADDR_W-1:0];
                    unreach_n = (OMDR == INF);
                    last_n    = (rd_addr == LAST_ADDR);
                    rd_addr_n = rd_addr + ONE;
                end else if (accept) begin
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            rd_addr       <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_index     <= '0;
            out_unreach   <= 1'b0;
            out_neg       <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            unreach_count <= '0;
        end else begin
            state         <= state_n;
            rd_addr       <= rd_addr_n;
            out_valid     <= valid_n;
            out_data      <= data_n;
            out_index     <= index_n;
            out_unreach   <= unreach_n;
            out_neg       <= neg_n;
            out_last      <= last_n;
            busy          <= busy_n;
            unreach_count <= count_n;
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain with an 8-entry memory filling the whole 3-bit address space.
module tb_result_drain;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int DP = 8;

    logic          clock = 1'b0;
    logic          reset, Finish, NegCycle, out_ready;
    logic [AW-1:0] OMAR;
    logic [DW-1:0] OMDR;
    logic          out_valid, out_unreach, out_neg, out_last, busy;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic [AW:0]   unreach_count;

    logic [DW-1:0] mem [DP];
    logic [AW-1:0] omar_hold;

    int vectors     = 0;
    int miscompares = 0;

    result_drain #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DP),
        .INF    (16'hFFFF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .Finish        (Finish),
        .NegCycle      (NegCycle),
        .OMAR          (OMAR),
        .OMDR          (OMDR),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_unreach   (out_unreach),
        .out_neg       (out_neg),
        .out_last      (out_last),
        .busy          (busy),
        .unreach_count (unreach_count)
    );

    assign OMDR = mem[OMAR];

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_unreach();
        int n = 0;
        for (int i = 0; i < DP; i++) if (mem[i] == 16'hFFFF) n++;
        return n;
    endfunction

    // Raise Finish from low; first word must appear two edges later.
    task automatic start_drain();
        Finish = 1'b1;
        tick();
        check("start_busy", 32'(busy), 32'd1);
        check("start_novalid", 32'(out_valid), 32'd0);
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
    endtask

    // Consume one full drain; pat gives out_ready per cycle (bit cyc%4).
    task automatic collect(input logic [3:0] pat, input int exp_cycles);
        int idx = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic [DW-1:0] hd = '0;
        logic [AW-1:0] hi = '0;
        while (idx < DP && cyc < 64) begin
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(hd));
                check("stall_index", 32'(out_index), 32'(hi));
            end
            out_ready = pat[cyc % 4];
            held = 1'b0;
            if (out_valid && out_ready) begin
                check("word_index", 32'(out_index), 32'(idx));
                check("word_data", 32'(out_data), 32'(mem[idx]));
                check("word_unreach", 32'(out_unreach), 32'(mem[idx] == 16'hFFFF));
                check("word_last", 32'(out_last), 32'(idx == DP - 1));
                check("word_neg", 32'(out_neg), 32'd0);
                idx++;
            end else if (out_valid) begin
                held = 1'b1;
                hd = out_data;
                hi = out_index;
            end
            tick();
            cyc++;
        end
        check("drain_words", 32'(idx), 32'(DP));
        if (exp_cycles > 0) check("drain_cycles", 32'(cyc), 32'(exp_cycles));
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_unreach_count", 32'(unreach_count), 32'(exp_unreach()));
        out_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        Finish    = 1'b0;
        NegCycle  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DP; i++) mem[i] = 16'(i);
        tick();
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(unreach_count), 32'd0);
        check("rst_omar", 32'(OMAR), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_neg", 32'(out_neg), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Plain drain at full throughput.
        start_drain();
        collect(4'b1111, DP);
        Finish = 1'b0;
        tick();

        // Unreachable entries at 3 and 5.
        mem[3] = 16'hFFFF;
        mem[5] = 16'hFFFF;
        start_drain();
        collect(4'b1111, DP);
        Finish = 1'b0;
        tick();

        // Backpressure pattern 1,0,0,1 repeating.
        start_drain();
        collect(4'b1001, 0);
        Finish = 1'b0;
        tick();

        // Simultaneous NegCycle and Finish: NegCycle wins, one status word.
        omar_hold = OMAR;
        out_ready = 1'b0;
        NegCycle  = 1'b1;
        Finish    = 1'b1;
        tick();
        check("neg_busy", 32'(busy), 32'd1);
        check("neg_novalid", 32'(out_valid), 32'd0);
        tick();
        check("neg_valid", 32'(out_valid), 32'd1);
        check("neg_flag", 32'(out_neg), 32'd1);
        check("neg_last", 32'(out_last), 32'd1);
        check("neg_data", 32'(out_data), 32'd0);
        check("neg_index", 32'(out_index), 32'd0);
        tick();
        check("neg_hold_valid", 32'(out_valid), 32'd1);
        check("neg_omar", 32'(OMAR), 32'(omar_hold));
        out_ready = 1'b1;
        tick();
        check("neg_done_valid", 32'(out_valid), 32'd0);
        check("neg_done_busy", 32'(busy), 32'd0);
        check("neg_done_omar", 32'(OMAR), 32'(omar_hold));
        tick();
        tick();
        check("neg_no_drain", 32'(busy), 32'd0);
        NegCycle = 1'b0;
        Finish   = 1'b0;
        tick();

        // Reset while the 4th word (index 3) is being accepted.
        mem[1] = 16'hFFFF;
        start_drain();
        tick();
        tick();
        tick();
        check("mid_index", 32'(out_index), 32'd3);
        check("mid_count", 32'(unreach_count), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(unreach_count), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("held_level_no_trigger", 32'(busy), 32'd0);
        Finish = 1'b0;
        tick();
        start_drain();
        collect(4'b1111, DP);

        // Finish still high after the drain: no second drain until a fresh edge.
        tick();
        tick();
        tick();
        tick();
        tick();
        check("no_redrain_busy", 32'(busy), 32'd0);
        check("no_redrain_valid", 32'(out_valid), 32'd0);
        Finish = 1'b0;
        tick();
        start_drain();
        collect(4'b1001, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
